// File: rtl/hazard_control.sv
// hazard_control: pipeline hazard sequencer for a simple in-order core.
//   Resolves taken branches (two-cycle flush), load-use hazards (one-cycle
//   stall plus bubble) and, optionally, multi-cycle multiplies that hold the
//   execute stage.
// Optional feature macro: HAZARD_MUL_EN (multiply sequencing; when undefined
//   mul_start is ignored, MUL is unreachable and execute_hold is tied 0).
// Ports:
//   clock, reset_n                      clock / async active-low reset
//   decode_a/b_register_address         decode-stage source operands
//   execute_dest_register_address       execute-stage destination
//   execute_mem_read_ctrl               execute instruction is a load
//   execute_register_write_ctrl         execute instruction writes a register
//   branch_taken                        branch resolved taken in execute
//   mul_start                           execute instruction is a multiply
//   fetch_stall, decode_stall           hold PC and FETCH_DECODE register
//   fetch_decode_flush                  bubble into FETCH_DECODE
//   decode_execute_flush                bubble into DECODE_EXECUTE
//   execute_hold                        freeze EXECUTE and DECODE_EXECUTE
//   state                               RUN=0, FLUSH=1, MUL=2
//
// state | meaning
// RUN   | normal issue; hazards evaluated every cycle
// FLUSH | second cycle of a taken branch, kill the in-flight fetch
// MUL   | multiply occupying execute; hold until counter reaches 0
module hazard_control #(
    parameter int REG_ADDR_W = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] decode_a_register_address,
    input  logic [REG_ADDR_W-1:0] decode_b_register_address,
    input  logic [REG_ADDR_W-1:0] execute_dest_register_address,
    input  logic                  execute_mem_read_ctrl,
    input  logic                  execute_register_write_ctrl,
    input  logic                  branch_taken,
    input  logic                  mul_start,
    output logic                  fetch_stall,
    output logic                  decode_stall,
    output logic                  fetch_decode_flush,
    output logic                  decode_execute_flush,
    output logic                  execute_hold,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        MUL   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   load_use;
    logic   run_eval;
    logic   fetch_stall_c, decode_stall_c, fd_flush_c, de_flush_c, hold_c;

    assign load_use = execute_mem_read_ctrl & execute_register_write_ctrl &
                      ((execute_dest_register_address == decode_a_register_address) |
                       (execute_dest_register_address == decode_b_register_address));

`ifdef HAZARD_MUL_EN
    // The start cycle already counts as one execute cycle, and the cycle
    // seen with counter==0 is the last one, hence the -2.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

    logic [3:0] count_q, count_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count_q <= 4'd0;
        else          count_q <= count_d;
    end
`else
    logic [4:0] unused_cfg;
    assign unused_cfg = {mul_start, 4'(MUL_CYCLES)};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        run_eval       = 1'b0;
        fetch_stall_c  = 1'b0;
        decode_stall_c = 1'b0;
        fd_flush_c     = 1'b0;
        de_flush_c     = 1'b0;
        hold_c         = 1'b0;
`ifdef HAZARD_MUL_EN
        count_d        = count_q;
`endif
        case (state_q)
            FLUSH: begin
                fd_flush_c = 1'b1;
                state_d    = RUN;
            end
            MUL: begin
`ifdef HAZARD_MUL_EN
                if (count_q != 4'd0) begin
                    hold_c         = 1'b1;
                    fetch_stall_c  = 1'b1;
                    decode_stall_c = 1'b1;
                    count_d        = count_q - 4'd1;
                end else begin
                    run_eval = 1'b1;
                end
`else
                state_d = RUN;
`endif
            end
            default: run_eval = 1'b1;
        endcase

        // Final multiply cycle behaves exactly like RUN, so both share this.
        if (run_eval) begin
            state_d = RUN;
            if (branch_taken) begin
                fd_flush_c = 1'b1;
                de_flush_c = 1'b1;
                state_d    = FLUSH;
            end else if (load_use) begin
                fetch_stall_c  = 1'b1;
                decode_stall_c = 1'b1;
                de_flush_c     = 1'b1;
            end
`ifdef HAZARD_MUL_EN
            else if (mul_start) begin
                hold_c         = 1'b1;
                fetch_stall_c  = 1'b1;
                decode_stall_c = 1'b1;
                count_d        = MUL_LOAD;
                state_d        = MUL;
            end
`endif
        end
    end

    // Outputs are forced low while reset is asserted, whatever the inputs do.
    assign fetch_stall          = reset_n & fetch_stall_c;
    assign decode_stall         = reset_n & decode_stall_c;
    assign fetch_decode_flush   = reset_n & fd_flush_c;
    assign decode_execute_flush = reset_n & de_flush_c;
    assign execute_hold         = reset_n & hold_c;
    assign state                = state_q;

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] a, b, dest;
    logic       mr, rw, br, mul;
    logic       fetch_stall, decode_stall, fd_flush, de_flush, hold;
    logic [1:0] state;

    int n_vec = 0;
    int n_bad = 0;

    // Expected-output encoding: {fs, ds, fdf, def, hold, state[1:0]}
    localparam logic [6:0] IDLE     = 7'b0000000;
    localparam logic [6:0] LU_STALL = 7'b1101000;
    localparam logic [6:0] BR_RUN   = 7'b0011000;
    localparam logic [6:0] BR_FLUSH = 7'b0010001;
    localparam logic [6:0] MUL_GO   = 7'b1100100;
    localparam logic [6:0] MUL_HOLD = 7'b1100110;
    localparam logic [6:0] MUL_LAST = 7'b0000010;
    localparam logic [6:0] LU_MUL0  = 7'b1101010;

    typedef struct {
        logic [3:0] a, b, dest;
        logic       mr, rw, br, mul;
        logic [6:0] exp;
    } vec_t;

    hazard_control #(.REG_ADDR_W(4), .MUL_CYCLES(4)) dut (
        .clock                         (clock),
        .reset_n                       (reset_n),
        .decode_a_register_address     (a),
        .decode_b_register_address     (b),
        .execute_dest_register_address (dest),
        .execute_mem_read_ctrl         (mr),
        .execute_register_write_ctrl   (rw),
        .branch_taken                  (br),
        .mul_start                     (mul),
        .fetch_stall                   (fetch_stall),
        .decode_stall                  (decode_stall),
        .fetch_decode_flush            (fd_flush),
        .decode_execute_flush          (de_flush),
        .execute_hold                  (hold),
        .state                         (state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] ta, tb, td,
                         input logic tmr, trw, tbr, tmul);
        a = ta; b = tb; dest = td; mr = tmr; rw = trw; br = tbr; mul = tmul;
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {fetch_stall, decode_stall, fd_flush, de_flush, hold, state};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (fs ds fdf def hold state)",
                     name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, sample just after, before the next posedge.
    task automatic step(input string name, input logic [3:0] ta, tb, td,
                        input logic tmr, trw, tbr, tmul, input logic [6:0] exp);
        @(negedge clock);
        drive(ta, tb, td, tmr, trw, tbr, tmul);
        #1;
        check(name, exp);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[1]  = '{4'd3, 4'd6, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, LU_STALL};
        vecs[2]  = '{4'd3, 4'd6, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[3]  = '{4'd2, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, LU_STALL};
        vecs[4]  = '{4'd2, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, LU_STALL};
        vecs[5]  = '{4'd2, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[6]  = '{4'd2, 4'd5, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, IDLE};
        vecs[7]  = '{4'd0, 4'd9, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, LU_STALL};
        vecs[8]  = '{4'd1, 4'd1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};
        vecs[9]  = '{4'd4, 4'd4, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, BR_RUN};
        vecs[10] = '{4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, BR_FLUSH};
        vecs[11] = '{4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[12] = '{4'd3, 4'd1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, BR_RUN};
        vecs[13] = '{4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, BR_FLUSH};
        vecs[14] = '{4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[15] = '{4'd15, 4'd2, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, LU_STALL};

        // Reset with a load-use match on the inputs: outputs must stay 0.
        reset_n = 1'b0;
        drive(4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("reset_outputs", IDLE);
        @(negedge clock);
        @(negedge clock);
        #1;
        check("reset_held", IDLE);
        drive(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++)
            step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].dest,
                 vecs[i].mr, vecs[i].rw, vecs[i].br, vecs[i].mul, vecs[i].exp);
        step("after_vecs", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

        // Reset during FLUSH abandons the flush.
        step("rf_branch", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, BR_RUN);
        step("rf_flush",  4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, BR_FLUSH);
        reset_n = 1'b0;
        #1;
        check("rf_async", IDLE);
        @(negedge clock);
        reset_n = 1'b1;
        step("rf_after", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

`ifdef HAZARD_MUL_EN
        // Multiply with an ignored branch in cycle 2.
        step("mul_c0", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, MUL_GO);
        step("mul_c1", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, MUL_HOLD);
        step("mul_c2", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, MUL_HOLD);
        step("mul_c3", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, MUL_LAST);
        step("mul_c4", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

        // Load-use ignored while holding, honoured on the final cycle.
        step("mlu_c0", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, MUL_GO);
        step("mlu_c1", 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, MUL_HOLD);
        step("mlu_c2", 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, MUL_HOLD);
        step("mlu_c3", 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, LU_MUL0);
        step("mlu_c4", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

        // Reset in cycle 1 of a multiply.
        step("rm_c0", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, MUL_GO);
        step("rm_c1", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, MUL_HOLD);
        reset_n = 1'b0;
        #1;
        check("rm_async", IDLE);
        @(negedge clock);
        reset_n = 1'b1;
        step("rm_after0", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        step("rm_after1", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
`else
        // mul_start has no effect without the multiply feature.
        for (int i = 0; i < 5; i++)
            step($sformatf("mul_off%0d", i), 4'd0, 4'd0, 4'd7,
                 1'b0, 1'b0, 1'b0, 1'b1, IDLE);
        step("mul_off_lu", 4'd6, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, LU_STALL);
        step("mul_off_end", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
